// File: rtl/clk_div_pkg.sv
// Shared constants and types for the multi-channel clock divider.
package clk_div_pkg;

  localparam int MIN_DIV  = 2;
  localparam int CH_IDX_W = 3;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_fsm_e;

  typedef struct packed {
    ch_fsm_e fsm;
    logic    clk2;
    logic    tick;
  } ch_state_t;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: ratio register, period counter, registered clk2/tick.
// CLKDIV_GLITCHFREE_EN defers ratio changes to the next period wrap.
//
// state   | meaning
// CH_IDLE | disabled or just reset; next enabled edge starts a period at cnt=0
// CH_RUN  | counting 0..D-1 and driving clk2/tick
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         wr,
  input  logic [W-1:0] wr_val,
  output logic         clk2,
  output logic         tick
);

  localparam logic [W-1:0] RST_DIV = (DEFAULT_DIV < MIN_DIV) ? W'(MIN_DIV) : W'(DEFAULT_DIV);

  ch_state_t    st_q, st_d;
  ch_fsm_e      fsm_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] d_q, d_d;
  logic [W-1:0] wval, half_hi;
  logic         wrap, restart;
`ifdef CLKDIV_GLITCHFREE_EN
  logic         pend_q, pend_d;
  logic [W-1:0] dp_q, dp_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= '{fsm: CH_IDLE, clk2: 1'b0, tick: 1'b0};
      cnt_q  <= '0;
      d_q    <= RST_DIV;
`ifdef CLKDIV_GLITCHFREE_EN
      pend_q <= 1'b0;
      dp_q   <= RST_DIV;
`endif
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      d_q    <= d_d;
`ifdef CLKDIV_GLITCHFREE_EN
      pend_q <= pend_d;
      dp_q   <= dp_d;
`endif
    end
  end

  always_comb begin
    fsm_d = en ? CH_RUN : CH_IDLE;
  end

  always_comb begin
    wval = (wr_val < W'(MIN_DIV)) ? W'(MIN_DIV) : wr_val;
    wrap = (st_q.fsm == CH_RUN) && en && (cnt_q >= d_q - 1'b1);
    restart = !en || (st_q.fsm == CH_IDLE) || wrap;
    d_d  = d_q;
`ifdef CLKDIV_GLITCHFREE_EN
    pend_d = pend_q;
    dp_d   = dp_q;
    // No period in flight (or one just ending): a pending or fresh ratio lands now.
    if (restart) begin
      d_d    = wr ? wval : (pend_q ? dp_q : d_q);
      pend_d = 1'b0;
    end else if (wr) begin
      dp_d   = wval;
      pend_d = 1'b1;
    end
`else
    if (wr) begin
      d_d = wval;
    end
    restart = restart || wr;
`endif
    cnt_d   = restart ? '0 : cnt_q + 1'b1;
    half_hi = d_d - (d_d >> 1);
    st_d.fsm  = fsm_d;
    st_d.clk2 = en && (cnt_d < half_hi);
    st_d.tick = en && (cnt_d == d_d - 1'b1);
  end

  assign clk2 = st_q.clk2;
  assign tick = st_q.tick;

endmodule

// File: rtl/clk_div_multi.sv
// NCH independent clock dividers sharing one ratio-write port with ack/err.
// Ratio update timing depends on CLKDIV_GLITCHFREE_EN (see clk_div_ch).
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH-1:0]      en,
  input  logic                div_wr,
  input  logic [CH_IDX_W-1:0] div_ch,
  input  logic [W-1:0]        div_val,
  output logic                div_ack,
  output logic                div_err,
  output logic [NCH-1:0]      clk2,
  output logic [NCH-1:0]      tick
);

  logic [NCH-1:0] wr_hit;
  logic           bad_ch;

  assign bad_ch = 32'(div_ch) >= NCH;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_ack <= 1'b0;
      div_err <= 1'b0;
    end else begin
      div_ack <= div_wr;
      div_err <= div_wr && bad_ch;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign wr_hit[i] = div_wr && (32'(div_ch) == i);

    clk_div_ch #(
      .W           (W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (en[i]),
      .wr     (wr_hit[i]),
      .wr_val (div_val),
      .clk2   (clk2[i]),
      .tick   (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed scenarios plus random traffic
// against a time-modulo reference model. Honours CLKDIV_GLITCHFREE_EN.
module tb_clk_div_multi;

  localparam int NCH   = 4;
  localparam int W     = 8;
  localparam int DEF_D = 2;
  localparam int RST_D = (DEF_D < 2) ? 2 : DEF_D;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] en;
  logic           div_wr;
  logic [2:0]     div_ch;
  logic [W-1:0]   div_val;
  logic           div_ack, div_err;
  logic [NCH-1:0] clk2, tick;

  clk_div_multi #(.NCH(NCH), .W(W), .DEFAULT_DIV(DEF_D)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div_wr  (div_wr),
    .div_ch  (div_ch),
    .div_val (div_val),
    .div_ack (div_ack),
    .div_err (div_err),
    .clk2    (clk2),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: each channel output is a function of (edge - period start) mod D
  int             k = 0;
  int             dm   [NCH];
  int             ts   [NCH];
  int             dpn  [NCH];
  bit             run  [NCH];
  bit             pend [NCH];
  logic [NCH-1:0] exp_clk2 = '0, exp_tick = '0;
  logic           exp_ack = 1'b0, exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      dm[i] = RST_D; ts[i] = 0; dpn[i] = RST_D; run[i] = 1'b0; pend[i] = 1'b0;
    end
    exp_clk2 = '0; exp_tick = '0; exp_ack = 1'b0; exp_err = 1'b0;
  endtask

  task automatic model_edge(input logic r, input logic [NCH-1:0] e, input logic w,
                            input logic [2:0] c, input logic [W-1:0] v);
    int  vv, ph;
    bit  hit;
    k++;
    if (r) begin
      model_reset();
      return;
    end
    exp_ack = w;
    exp_err = w && (int'(c) >= NCH);
    vv = (int'(v) < 2) ? 2 : int'(v);
    for (int i = 0; i < NCH; i++) begin
      hit = w && (int'(c) == i);
      if (!e[i] || !run[i]) begin
        if (hit) dm[i] = vv;
        else if (pend[i]) dm[i] = dpn[i];
        pend[i] = 1'b0;
        run[i]  = e[i];
        ts[i]   = k;
      end else begin
`ifdef CLKDIV_GLITCHFREE_EN
        if ((k - ts[i]) % dm[i] == 0) begin
          if (hit) dm[i] = vv;
          else if (pend[i]) dm[i] = dpn[i];
          pend[i] = 1'b0;
          ts[i]   = k;
        end else if (hit) begin
          pend[i] = 1'b1;
          dpn[i]  = vv;
        end
`else
        if (hit) begin
          dm[i] = vv;
          ts[i] = k;
        end
`endif
      end
      if (e[i]) begin
        ph = (k - ts[i]) % dm[i];
        exp_clk2[i] = ph < (dm[i] - dm[i] / 2);
        exp_tick[i] = (ph == dm[i] - 1);
      end else begin
        exp_clk2[i] = 1'b0;
        exp_tick[i] = 1'b0;
      end
    end
  endtask

  // Check outputs of the previous edge, then drive inputs for the next one.
  task automatic step(input logic r, input logic [NCH-1:0] e, input logic w,
                      input logic [2:0] c, input logic [W-1:0] v, input string tag);
    @(negedge clk);
    check({tag, ".clk2"}, 32'(clk2), 32'(exp_clk2));
    check({tag, ".tick"}, 32'(tick), 32'(exp_tick));
    check({tag, ".ack"},  32'(div_ack), 32'(exp_ack));
    check({tag, ".err"},  32'(div_err), 32'(exp_err));
    rst = r; en = e; div_wr = w; div_ch = c; div_val = v;
    model_edge(r, e, w, c, v);
  endtask

  initial begin
    logic [NCH-1:0] e_r;
    logic           r_r, w_r;
    logic [2:0]     c_r;
    logic [W-1:0]   v_r;
    int             n;

    rst = 1'b1; en = '0; div_wr = 1'b0; div_ch = '0; div_val = '0;
    model_reset();

    for (int i = 0; i < 3; i++) step(1'b1, 4'b0000, 1'b0, 3'd0, 8'd0, "reset");
    // write coincident with reset is lost
    step(1'b1, 4'b1111, 1'b1, 3'd1, 8'd9, "rst_wr");

    for (int i = 0; i < 8; i++) step(1'b0, 4'b0001, 1'b0, 3'd0, 8'd0, "d2_ch0");

    step(1'b0, 4'b0001, 1'b1, 3'd1, 8'd5, "wr_ch1");
    for (int i = 0; i < 12; i++) step(1'b0, 4'b0011, 1'b0, 3'd0, 8'd0, "d5_ch1");

    step(1'b0, 4'b0011, 1'b1, 3'd6, 8'd3, "wr_bad");
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0011, 1'b0, 3'd0, 8'd0, "after_bad");

    step(1'b0, 4'b0011, 1'b1, 3'd2, 8'd4, "wr_ch2");
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0111, 1'b0, 3'd0, 8'd0, "d4_ch2");
    n = 0;
    while (((k - ts[2]) % dm[2]) != 1 && n < 10) begin
      step(1'b0, 4'b0111, 1'b0, 3'd0, 8'd0, "align_ch2");
      n++;
    end
    check("align_budget", 32'(n < 10), 32'd1);
    step(1'b0, 4'b0111, 1'b1, 3'd2, 8'd6, "wr_ch2_d6");
    for (int i = 0; i < 16; i++) step(1'b0, 4'b0111, 1'b0, 3'd0, 8'd0, "d6_ch2");

    step(1'b0, 4'b0111, 1'b1, 3'd3, 8'd0, "wr_ch3_0");
    for (int i = 0; i < 8; i++) step(1'b0, 4'b1111, 1'b0, 3'd0, 8'd0, "d0_ch3");

    // back-to-back writes, last one wins
    step(1'b0, 4'b1111, 1'b1, 3'd0, 8'd3, "b2b_a");
    step(1'b0, 4'b1111, 1'b1, 3'd0, 8'd7, "b2b_b");
    for (int i = 0; i < 10; i++) step(1'b0, 4'b1111, 1'b0, 3'd0, 8'd0, "d7_ch0");
    step(1'b1, 4'b1111, 1'b0, 3'd0, 8'd0, "mid_rst");
    for (int i = 0; i < 6; i++) step(1'b0, 4'b1111, 1'b0, 3'd0, 8'd0, "post_rst");

    for (int i = 0; i < 3000; i++) begin
      r_r = ($urandom_range(0, 99) == 0);
      e_r = ($urandom_range(0, 15) == 0) ? NCH'($urandom) : en;
      w_r = ($urandom_range(0, 5) == 0);
      c_r = 3'($urandom_range(0, 7));
      v_r = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 9));
      step(r_r, e_r, w_r, c_r, v_r, "rand");
    end
    step(1'b0, en, 1'b0, 3'd0, 8'd0, "final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
